// File: rtl/aes256_dec_sequencer.sv
// aes256_dec_sequencer
// Iterative AES-256 decryption controller. One shared combinational key-expansion
// step and one shared inverse-round unit sit outside this block; the sequencer
// drives them one step per cycle, keeps the 15 round keys in a local table, can
// reuse that table for following blocks, and talks valid/ready on both sides.
//
// Timeline of one block (T = accept cycle):
//   miss : EXPAND T+1..T+7, INIT T+8, ROUND T+9..T+22, DONE from T+23
//   hit  : INIT T+1, ROUND T+2..T+15, DONE from T+16

module aes256_dec_sequencer #(
  parameter int NR       = 14,     // AES-256 only
  parameter int KX_STEPS = 7,      // AES-256 only
  parameter bit CACHE_EN = 1'b1    // 1: honour key_reuse, 0: always expand
) (
  input  logic         clk,
  input  logic         rst_n,
  // request side
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic [255:0] in_key,
  input  logic         key_reuse,
  // result side
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  // shared key-expansion step
  output logic [3:0]   kx_rc_o,
  output logic [255:0] kx_key_o,
  input  logic [255:0] kx_key_i,
  // shared inverse-round unit
  output logic [127:0] rnd_data_o,
  output logic [127:0] rnd_key_o,
  output logic         rnd_last_o,
  input  logic [127:0] rnd_data_i
);

  localparam logic [2:0] KX_LAST  = 3'(KX_STEPS - 1);
  localparam logic [3:0] RND_LAST = 4'(NR);
  localparam logic [3:0] RK_TOP   = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_INIT   = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [2:0]   r_kcnt;                 // expansion step k, 0..6
  logic [3:0]   r_rcnt;                 // round index i, 1..14
  logic [127:0] r_rk [0:NR];            // round-key table rk0..rk14
  logic [255:0] r_work;                 // key presented to the expansion step
  logic [127:0] r_blk;                  // latched ciphertext, then cipher state
  logic         r_cache_vld;
  logic         r_out_valid;
  logic [127:0] r_out_data;
  logic         r_busy;
  logic         r_in_ready;

  logic         w_accept;
  logic         w_hit;
  logic         w_kx_last;
  logic         w_rnd_last;
  logic [3:0]   w_rk_even_idx;
  logic [3:0]   w_rk_odd_idx;
  logic [3:0]   w_rk_rnd_idx;

  // A request is only taken while idle; anything presented while busy is dropped.
  assign w_accept      = in_valid & (r_state == S_IDLE);
  assign w_hit         = key_reuse & r_cache_vld & CACHE_EN;
  assign w_kx_last     = (r_kcnt == KX_LAST);
  assign w_rnd_last    = (r_rcnt == RND_LAST);
  // Step k produces rk[2k+2] (upper half) and rk[2k+3] (lower half).
  assign w_rk_even_idx = {r_kcnt, 1'b0} + 4'd2;
  assign w_rk_odd_idx  = {r_kcnt, 1'b0} + 4'd3;
  // Decryption walks the table downwards: round i uses rk[14-i].
  assign w_rk_rnd_idx  = RK_TOP - r_rcnt;

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // State register plus the status flags that follow the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_in_ready <= (w_state_nxt == S_IDLE);
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_hit) begin
            w_state_nxt = S_INIT;
          end else begin
            w_state_nxt = S_EXPAND;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXPAND: begin
        if (w_kx_last) begin
          w_state_nxt = S_INIT;
        end else begin
          w_state_nxt = S_EXPAND;
        end
      end
      S_INIT: begin
        w_state_nxt = S_ROUND;
      end
      S_ROUND: begin
        if (w_rnd_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ROUND;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Drive the shared units only while they are in use; zero otherwise.
  always_comb begin
    kx_rc_o    = 4'd0;
    kx_key_o   = 256'd0;
    rnd_data_o = 128'd0;
    rnd_key_o  = 128'd0;
    rnd_last_o = 1'b0;
    case (r_state)
      S_EXPAND: begin
        kx_rc_o  = {1'b0, r_kcnt};
        kx_key_o = r_work;
      end
      S_ROUND: begin
        rnd_data_o = r_blk;
        rnd_key_o  = r_rk[w_rk_rnd_idx];
        rnd_last_o = w_rnd_last;
      end
      default: begin
        kx_rc_o    = 4'd0;
        kx_key_o   = 256'd0;
        rnd_data_o = 128'd0;
        rnd_key_o  = 128'd0;
        rnd_last_o = 1'b0;
      end
    endcase
  end

  // Datapath: counters, round-key table, cipher state, cache flag and result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_kcnt      <= 3'd0;
      r_rcnt      <= 4'd0;
      r_work      <= 256'd0;
      r_blk       <= 128'd0;
      r_cache_vld <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 128'd0;
      for (int i = 0; i <= NR; i++) begin
        r_rk[i] <= 128'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_blk  <= in_data;
            r_kcnt <= 3'd0;
            r_rcnt <= 4'd0;
            // On a hit the table already holds the right keys and in_key is ignored.
            if (!w_hit) begin
              r_cache_vld <= 1'b0;
              r_work      <= in_key;
              r_rk[0]     <= in_key[255:128];
              r_rk[1]     <= in_key[127:0];
            end
          end
        end
        S_EXPAND: begin
          r_rk[w_rk_even_idx] <= kx_key_i[255:128];
          // The last step's lower half would be rk15, which AES-256 never uses.
          if (w_rk_odd_idx <= RK_TOP) begin
            r_rk[w_rk_odd_idx] <= kx_key_i[127:0];
          end
          r_work <= kx_key_i;
          if (w_kx_last) begin
            r_kcnt      <= 3'd0;
            r_cache_vld <= 1'b1;
          end else begin
            r_kcnt <= r_kcnt + 3'd1;
          end
        end
        S_INIT: begin
          r_blk  <= r_blk ^ r_rk[RK_TOP];
          r_rcnt <= 4'd1;
        end
        S_ROUND: begin
          r_blk <= rnd_data_i;
          if (w_rnd_last) begin
            r_out_data  <= rnd_data_i;
            r_out_valid <= 1'b1;
            r_rcnt      <= 4'd0;
          end else begin
            r_rcnt <= r_rcnt + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes256_dec_sequencer.sv
// Bench for aes256_dec_sequencer. Supplies behavioural key-expansion and
// inverse-round units, runs a table of blocks (FIPS-197 C.3 plus random ones)
// against a whole-block AES-256 reference decryptor, and adds hand-written
// sequences for mid-operation reset. A second instance has CACHE_EN=0.
module tb_aes256_dec_sequencer;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;

  // ---------------- AES helper functions ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, e;
    r = 8'h01; e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (e[i]) r = gmul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int b);
    return s[127-8*b -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        r[127-8*(row+4*c) -: 8] = gb(s, row + 4*((c - row + 4) % 4));
    return r;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = inv_sbox(gb(s, b));
    return r;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      r[127-8*(4*c)   -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
      r[127-8*(4*c+1) -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
      r[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
      r[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
    end
    return r;
  endfunction

  // ---------------- behavioural external units ----------------
  // one key-expansion step: 8 new schedule words from the previous 8
  function automatic logic [255:0] kx_step(input logic [255:0] k, input logic [3:0] rc);
    logic [31:0] w [0:7];
    logic [31:0] n [0:7];
    for (int i = 0; i < 8; i++) w[i] = k[255-32*i -: 32];
    n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {(8'h01 << rc), 24'h0};
    n[1] = w[1] ^ n[0]; n[2] = w[2] ^ n[1]; n[3] = w[3] ^ n[2];
    n[4] = w[4] ^ sub_word(n[3]);
    n[5] = w[5] ^ n[4]; n[6] = w[6] ^ n[5]; n[7] = w[7] ^ n[6];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k, input logic last);
    logic [127:0] t;
    t = inv_sub_bytes(inv_shift_rows(s)) ^ k;
    return last ? t : inv_mix_columns(t);
  endfunction

  // ---------------- reference: whole-block FIPS-197 inverse cipher ----------------
  function automatic logic [127:0] aes256_decrypt(input logic [127:0] ct, input logic [255:0] key);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [127:0] s;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0)      t = sub_word({t[23:0], t[31:24]}) ^ {(8'h01 << (i/8 - 1)), 24'h0};
      else if (i % 8 == 4) t = sub_word(t);
      w[i] = w[i-8] ^ t;
    end
    s = ct ^ {w[56], w[57], w[58], w[59]};
    for (int r = 13; r >= 1; r--)
      s = inv_mix_columns(inv_sub_bytes(inv_shift_rows(s)) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    s = inv_sub_bytes(inv_shift_rows(s)) ^ {w[0], w[1], w[2], w[3]};
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- DUTs and wiring ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, key_reuse, sel;
  logic [127:0] in_data;
  logic [255:0] in_key;

  logic         d0_in_valid, d0_out_ready, d0_in_ready, d0_out_valid, d0_busy, d0_rnd_last;
  logic [127:0] d0_out_data, d0_rnd_data, d0_rnd_key, d0_rnd_res;
  logic [3:0]   d0_kx_rc;
  logic [255:0] d0_kx_key, d0_kx_res;
  logic         d1_in_valid, d1_out_ready, d1_in_ready, d1_out_valid, d1_busy, d1_rnd_last;
  logic [127:0] d1_out_data, d1_rnd_data, d1_rnd_key, d1_rnd_res;
  logic [3:0]   d1_kx_rc;
  logic [255:0] d1_kx_key, d1_kx_res;

  assign d0_in_valid  = in_valid & ~sel;
  assign d1_in_valid  = in_valid & sel;
  assign d0_out_ready = out_ready & ~sel;
  assign d1_out_ready = out_ready & sel;
  assign d0_kx_res    = kx_step(d0_kx_key, d0_kx_rc);
  assign d1_kx_res    = kx_step(d1_kx_key, d1_kx_rc);
  assign d0_rnd_res   = inv_round(d0_rnd_data, d0_rnd_key, d0_rnd_last);
  assign d1_rnd_res   = inv_round(d1_rnd_data, d1_rnd_key, d1_rnd_last);

  aes256_dec_sequencer #(.NR(14), .KX_STEPS(7), .CACHE_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(d0_in_valid), .in_ready(d0_in_ready),
    .in_data(in_data), .in_key(in_key), .key_reuse(key_reuse),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_data(d0_out_data), .busy(d0_busy),
    .kx_rc_o(d0_kx_rc), .kx_key_o(d0_kx_key), .kx_key_i(d0_kx_res),
    .rnd_data_o(d0_rnd_data), .rnd_key_o(d0_rnd_key), .rnd_last_o(d0_rnd_last), .rnd_data_i(d0_rnd_res));

  aes256_dec_sequencer #(.NR(14), .KX_STEPS(7), .CACHE_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .in_data(in_data), .in_key(in_key), .key_reuse(key_reuse),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data), .busy(d1_busy),
    .kx_rc_o(d1_kx_rc), .kx_key_o(d1_kx_key), .kx_key_i(d1_kx_res),
    .rnd_data_o(d1_rnd_data), .rnd_key_o(d1_rnd_key), .rnd_last_o(d1_rnd_last), .rnd_data_i(d1_rnd_res));

  logic         m_in_ready, m_out_valid, m_busy, m_rnd_last;
  logic [127:0] m_out_data, m_rnd_data, m_rnd_key;
  logic [3:0]   m_kx_rc;
  logic [255:0] m_kx_key;
  assign m_in_ready  = sel ? d1_in_ready  : d0_in_ready;
  assign m_out_valid = sel ? d1_out_valid : d0_out_valid;
  assign m_busy      = sel ? d1_busy      : d0_busy;
  assign m_out_data  = sel ? d1_out_data  : d0_out_data;
  assign m_kx_rc     = sel ? d1_kx_rc     : d0_kx_rc;
  assign m_kx_key    = sel ? d1_kx_key    : d0_kx_key;
  assign m_rnd_data  = sel ? d1_rnd_data  : d0_rnd_data;
  assign m_rnd_key   = sel ? d1_rnd_key   : d0_rnd_key;
  assign m_rnd_last  = sel ? d1_rnd_last  : d0_rnd_last;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [127:0] data;
    logic [255:0] key;
    logic         reuse;
    logic         sel;
    int           hold;
    int           garb;
    logic [127:0] exp_pt;
    int           exp_lat;
  } vec_t;

  vec_t         vecs[$];
  logic         mc_vld = 1'b0;   // model of instance 0's key cache
  logic [255:0] mc_key = 256'd0;

  // Append a vector; expectation derived from the cache rules and the reference cipher.
  task automatic add_vec(input logic [127:0] data, input logic [255:0] key, input logic reuse,
                         input logic s, input int hold, input int garb, input logic use_c3);
    vec_t v;
    logic hit;
    logic [255:0] ek;
    hit = reuse && mc_vld && !s;
    ek  = hit ? mc_key : key;
    if (!s && !hit) begin
      mc_vld = 1'b1;
      mc_key = key;
    end
    v.data = data; v.key = key; v.reuse = reuse; v.sel = s; v.hold = hold; v.garb = garb;
    v.exp_pt  = use_c3 ? C3_PT : aes256_decrypt(data, ek);
    v.exp_lat = hit ? 16 : 23;
    vecs.push_back(v);
  endtask

  task automatic run_block(input vec_t v);
    int lat;
    logic bad;
    logic [127:0] rec;
    sel = v.sel;
    @(negedge clk);
    chk("in_ready_before", m_in_ready, 1'b1);
    in_data = v.data; in_key = v.key; key_reuse = v.reuse; in_valid = 1'b1;
    lat = 0; bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        in_valid = 1'b0;
        chk("kx_rc_first", m_kx_rc, 4'd0);
        chk("kx_key_first", m_kx_key, (v.exp_lat == 23) ? v.key : 256'd0);
      end
      if (v.garb != 0 && c == v.garb) begin
        in_valid = 1'b1; in_data = rand128(); in_key = {rand128(), rand128()}; key_reuse = 1'b0;
      end
      if (v.garb != 0 && c == v.garb + 1) in_valid = 1'b0;
      if (!m_busy || m_in_ready) bad = 1'b1;
      if (m_out_valid) begin
        lat = c;
        break;
      end
    end
    in_valid = 1'b0;
    chk("latency", lat, v.exp_lat);
    chk("busy_while_running", bad, 1'b0);
    chk("plaintext", m_out_data, v.exp_pt);
    chk("units_idle_in_done", |{m_kx_rc, m_kx_key, m_rnd_data, m_rnd_key, m_rnd_last}, 1'b0);
    rec = m_out_data; bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!m_out_valid || m_out_data !== rec || m_in_ready) bad = 1'b1;
    end
    if (v.hold > 0) chk("hold_stable", bad, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handshake_to_idle", {m_out_valid, m_in_ready, m_busy}, 3'b010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic bad;
    logic [255:0] k1;

    // ---- vector table ----
    k1 = {rand128(), rand128()};
    add_vec(C3_CT, C3_KEY, 1'b0, 1'b0, 0, 0, 1'b1);                  // full expansion
    add_vec(C3_CT, 256'd0, 1'b1, 1'b0, 5, 0, 1'b1);                  // cache hit, held output
    add_vec(C3_CT, {rand128(), rand128()}, 1'b1, 1'b0, 0, 5, 1'b1);  // garbage pulse at T+5
    add_vec(C3_CT, 256'd0, 1'b1, 1'b0, 0, 0, 1'b1);                  // cache survived garbage
    add_vec(rand128(), k1, 1'b0, 1'b0, 0, 5, 1'b0);                  // new key
    add_vec(rand128(), {rand128(), rand128()}, 1'b1, 1'b0, 2, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      add_vec(rand128(), {rand128(), rand128()}, 1'($urandom_range(0, 1)), 1'b0, 0, 0, 1'b0);
    add_vec(C3_CT, C3_KEY, 1'b0, 1'b1, 0, 0, 1'b1);                  // CACHE_EN=0 instance
    add_vec(C3_CT, C3_KEY, 1'b1, 1'b1, 0, 0, 1'b1);                  // reuse ignored there

    // ---- reset ----
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key_reuse = 1'b0; sel = 1'b0;
    in_data = 128'd0; in_key = 256'd0;
    repeat (3) @(negedge clk);
    chk("reset_flags", {m_out_valid, m_busy, m_in_ready}, 3'b001);
    chk("reset_out_data", m_out_data, 128'd0);
    chk("reset_unit_outs", |{m_kx_rc, m_kx_key, m_rnd_data, m_rnd_key, m_rnd_last}, 1'b0);
    chk("ref_model_c3", aes256_decrypt(C3_CT, C3_KEY), C3_PT);
    rst_n = 1'b1;

    // ---- table ----
    foreach (vecs[i]) run_block(vecs[i]);

    // ---- reset during a block, then reuse must fall back to full expansion ----
    sel = 1'b0;
    @(negedge clk);
    in_data = C3_CT; in_key = C3_KEY; key_reuse = 1'b0; in_valid = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) in_valid = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_flags", {m_out_valid, m_busy, m_in_ready}, 3'b001);
    chk("midreset_out_data", m_out_data, 128'd0);
    bad = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (m_out_valid) bad = 1'b1;
    end
    chk("midreset_no_output", bad, 1'b0);
    v.data = C3_CT; v.key = C3_KEY; v.reuse = 1'b1; v.sel = 1'b0; v.hold = 0; v.garb = 0;
    v.exp_pt = C3_PT; v.exp_lat = 23;
    run_block(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
